maxpool2d: RTL
==============

Name: maxpool2d

Overview:
- Pooling stage directly downstream of the 2D convolution engine.
- After conv asserts done, this block reads the signed int8 result map through the conv output-memory read port and computes a windowed max-pool with optional ReLU.
- Results go to its own byte memory, which has the same 32-bit word read port style as conv, so a later stage or the host can fetch them.

Parameters:
- DSIZE, 1024, depth in bytes of the pooled output memory; also the source address space.
- PSIZE, 4, maximum pool window edge (pool_width, pool_height ≤ PSIZE).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- src_pitch  in  8  row pitch of the source map in bytes (conv writes results at x + data_width*y, so this equals data_width)
- pool_width  in  3  window width, 1..PSIZE
- pool_height  in  3  window height, 1..PSIZE
- stride_x  in  4  window step in x
- stride_y  in  4  window step in y
- out_width  in  8  pooled columns, precomputed by host
- out_height  in  8  pooled rows, precomputed by host
- relu_en  in  1  when 1, clamp negative results to 0
- src_addr  out  $clog2(DSIZE)+1  byte address to the conv mo_addr port
- src_data  in  32  conv mo_data; only [7:0] is used
- po_addr  in  $clog2(DSIZE)+1  output memory read byte address
- po_data  out  32  {PO[a+3],PO[a+2],PO[a+1],PO[a]}, combinational
- start  in  1  one-cycle start pulse
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: busy=0, done=0, src_addr=0, all counters=0, state=IDLE. PO contents are not reset.
- States:
  - IDLE: on start, latch all config inputs, go to FETCH.
  - FETCH: one source read issued per cycle. After the final read of the final window, go to DRAIN.
  - DRAIN: one cycle; the last sample is consumed and the last write is performed. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Counters:
  - wx (0..pool_width-1) is the innermost counter, then wy, ox (0..out_width-1), oy (0..out_height-1).
  - Each wraps to 0 when its limit is reached and carries to the next; same nesting as the conv counters.
- Address: src_addr = (ox*stride_x + wx) + src_pitch*(oy*stride_y + wy), 11-bit arithmetic, registered.
- Read latency: src_data is sampled exactly one cycle after src_addr changes. Sample-valid, first-of-window and last-of-window flags are pipelined by one stage alongside the address.
- Running max:
  - Comparison is signed 8-bit.
  - On a first-of-window sample, max <= sample. Otherwise max <= (sample > max) ? sample : max.
- Write:
  - On the cycle a last-of-window sample arrives, write PO[ox_d + out_width*oy_d] <= result.
  - result = relu_en && value[7] ? 8'h00 : value, where value is the final max including that sample.
  - Output is packed densely, not at source pitch.
- Latency: done pulses exactly out_width*out_height*pool_width*pool_height + 2 cycles after the start cycle.
- Boundaries:
  - start while busy is ignored.
  - pool_width or pool_height = 0 is treated as 1.
  - out_width or out_height = 0: no reads or writes; done pulses 2 cycles after start.
  - A 1x1 window with stride 1 is a pure copy, with ReLU if enabled.
  - Source addresses are not range-checked; the host guarantees they are in range.
  - rst mid-operation: immediate return to IDLE, no further PO writes, done not asserted.
  - po_data reads are legal while busy; they return the current PO contents.

Decomposition:
- Shared package conv_pkg:
  - state encodings IDLE/FETCH/DRAIN/DONE;
  - localparams INT8_MIN=8'h80, ADDR_W=$clog2(DSIZE)+1.
- One natural sub-module: pool_addr_gen, holding the four nested counters, the address multiply-add, and the first/last/valid flags.
- Max/ReLU datapath, FSM and PO memory stay in maxpool2d.

Test Plan:
- 4x4 source 0..15, pitch 4, 2x2 window, stride 2, out 2x2, relu_en=0 -> PO[0..3] = 5,7,13,15; done at start+18.
- Source all 8'hF0 (-16), 2x2/2, relu_en=0 -> every output = 8'hF0. Same with relu_en=1 -> every output = 8'h00.
- Window containing {-128, -1, 127, 0}, 2x2, out 1x1 -> PO[0] = 8'h7F; this checks the signed compare.
- 5x5 source, pitch 5, 3x3 window, stride 1, out 3x3 -> nine overlapping maxima match a software model; done at start+83.
- start pulsed again at cycle start+5 during the run -> ignored, single done. rst asserted at cycle start+6 -> busy=0 immediately, no done, PO locations not yet written keep their prior values.
- out_width=0 -> no src_addr changes, no PO writes, done at start+2.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and constants for the conv/pool pipeline
package conv_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  localparam int DSIZE_DEF = 1024;
  localparam int ADDR_W = $clog2(DSIZE_DEF) + 1;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: nested window/output counters, registered source address and one-stage sample flags
module pool_addr_gen
  import conv_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [2:0]    pw,
  input  logic [2:0]    ph,
  input  logic [3:0]    sx,
  input  logic [3:0]    sy,
  input  logic [7:0]    ow,
  input  logic [7:0]    oh,
  input  logic [7:0]    pitch,
  output logic [AW-1:0] addr,
  output logic          final_rd,
  output logic          vld_d,
  output logic          first_d,
  output logic          last_d,
  output logic [7:0]    ox_d,
  output logic [7:0]    oy_d
);
  logic [2:0] wx, wy;
  logic [7:0] ox, oy;
  logic wx_end, wy_end, ox_end, oy_end;
  logic [AW-1:0] col, row, addr_c;
  always_comb begin
    wx_end = wx == pw - 3'd1;
    wy_end = wy == ph - 3'd1;
    ox_end = ox == ow - 8'd1;
    oy_end = oy == oh - 8'd1;
    final_rd = wx_end && wy_end && ox_end && oy_end;
    col = AW'(ox) * AW'(sx) + AW'(wx);
    row = AW'(oy) * AW'(sy) + AW'(wy);
    addr_c = col + AW'(pitch) * row;
  end
  // counters wrap back to zero after the final read, so no explicit clear is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx <= '0;
      wy <= '0;
      ox <= '0;
      oy <= '0;
      addr <= '0;
      vld_d <= 1'b0;
      first_d <= 1'b0;
      last_d <= 1'b0;
      ox_d <= '0;
      oy_d <= '0;
    end else begin
      vld_d <= step;
      if (step) begin
        addr <= addr_c;
        first_d <= wx == 3'd0 && wy == 3'd0;
        last_d <= wx_end && wy_end;
        ox_d <= ox;
        oy_d <= oy;
        wx <= wx_end ? 3'd0 : wx + 3'd1;
        if (wx_end) wy <= wy_end ? 3'd0 : wy + 3'd1;
        if (wx_end && wy_end) ox <= ox_end ? 8'd0 : ox + 8'd1;
        if (wx_end && wy_end && ox_end) oy <= oy_end ? 8'd0 : oy + 8'd1;
      end
    end
  end
endmodule

// File: rtl/maxpool2d.sv
// maxpool2d: windowed signed max-pool with optional ReLU over the conv result map
module maxpool2d
  import conv_pkg::*;
#(
  parameter int DSIZE = 1024,
  parameter int PSIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 src_pitch,
  input  logic [2:0]                 pool_width,
  input  logic [2:0]                 pool_height,
  input  logic [3:0]                 stride_x,
  input  logic [3:0]                 stride_y,
  input  logic [7:0]                 out_width,
  input  logic [7:0]                 out_height,
  input  logic                       relu_en,
  output logic [$clog2(DSIZE):0]     src_addr,
  input  logic [31:0]                src_data,
  input  logic [$clog2(DSIZE):0]     po_addr,
  output logic [31:0]                po_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done
);
  localparam int AW = $clog2(DSIZE) + 1;
  localparam int MW = $clog2(DSIZE);
  state_t state, nxt;
  logic [2:0] pw, ph;
  logic [3:0] sx, sy;
  logic [7:0] ow, oh, pitch;
  logic relu, step, final_rd, vld_d, first_d, last_d;
  logic [7:0] ox_d, oy_d, res;
  logic signed [7:0] smp, mx, val;
  logic [7:0] po [DSIZE];
  logic [MW-1:0] pa, wa;
  logic unused_bits;
  function automatic logic [2:0] clamp_win(input logic [2:0] v);
    return v == 3'd0 ? 3'd1 : v > 3'(PSIZE) ? 3'(PSIZE) : v;
  endfunction
  pool_addr_gen #(.AW(AW)) u_gen (
    .clk(clk), .rst(rst), .step(step),
    .pw(pw), .ph(ph), .sx(sx), .sy(sy), .ow(ow), .oh(oh), .pitch(pitch),
    .addr(src_addr), .final_rd(final_rd), .vld_d(vld_d),
    .first_d(first_d), .last_d(last_d), .ox_d(ox_d), .oy_d(oy_d)
  );
  always_comb begin
    step = state == FETCH;
    busy = state != IDLE;
    done = state == DONE;
    nxt = state == IDLE  ? (start ? (out_width == 8'd0 || out_height == 8'd0 ? DRAIN : FETCH) : IDLE)
        : state == FETCH ? (final_rd ? DRAIN : FETCH)
        : state == DRAIN ? DONE : IDLE;
    smp = src_data[7:0];
    val = first_d || smp > mx ? smp : mx;
    res = relu && val[7] ? 8'h00 : val;
    pa = po_addr[MW-1:0];
    wa = MW'(ox_d) + MW'(ow) * MW'(oy_d);
    po_data = {po[pa + MW'(3)], po[pa + MW'(2)], po[pa + MW'(1)], po[pa]};
    unused_bits = ^{src_data[31:8], po_addr[MW]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pw <= '0;
      ph <= '0;
      sx <= '0;
      sy <= '0;
      ow <= '0;
      oh <= '0;
      pitch <= '0;
      relu <= 1'b0;
      mx <= INT8_MIN;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        pw <= clamp_win(pool_width);
        ph <= clamp_win(pool_height);
        sx <= stride_x;
        sy <= stride_y;
        ow <= out_width;
        oh <= out_height;
        pitch <= src_pitch;
        relu <= relu_en;
      end
      if (vld_d) mx <= val;
    end
  end
  // output memory is packed densely by output coordinate, not at source pitch
  always_ff @(posedge clk) begin
    if (vld_d && last_d) po[wa] <= res;
  end
endmodule
